// File: rtl/gearbox_input_arbiter.sv
// Round-robin, burst-granular arbiter feeding the 16-bit write side of the 16->20 gearbox.
// One holding register drives gb_shift_in/gb_data_in; words are never offered while it cannot drain.
module gearbox_input_arbiter #(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned MAX_BURST = 8
) (
   input  logic                 clk_400MHz,
   input  logic                 res_n,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [N_REQ-1:0]     req_last,
   input  logic [16*N_REQ-1:0]  req_data,
   output logic [N_REQ-1:0]     req_ready,
   input  logic                 gb_full,
   output logic                 gb_shift_in,
   output logic [15:0]          gb_data_in,
   output logic                 busy,
   output logic [2:0]           grant_id
);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e      state_q, state_d;
   logic [2:0]  grant_q, grant_d;
   logic [7:0]  beat_q, beat_d;
   logic        hold_valid_q, hold_valid_d;
   logic [15:0] hold_data_q, hold_data_d;

   logic        slot_free;
   logic        accept;
   logic        burst_end;
   logic [2:0]  pick;
   logic [2:0]  cand;
   logic        pick_found;

   // Requester vectors padded to the 8-requester maximum so a 3-bit grant indexes them directly.
   logic [7:0]   valid_pad;
   logic [7:0]   last_pad;
   logic [7:0]   ready_pad;
   logic [127:0] data_pad;

   assign valid_pad = 8'(req_valid);
   assign last_pad  = 8'(req_last);
   assign data_pad  = 128'(req_data);

   // First valid requester searching upward from the last grant, wrapping at N_REQ.
   always_comb begin
      pick       = grant_q;
      pick_found = 1'b0;
      cand       = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         cand = 3'((32'(grant_q) + i) % N_REQ);
         if (!pick_found && valid_pad[cand]) begin
            pick       = cand;
            pick_found = 1'b1;
         end
      end
   end

   // Load and drain may coincide, giving one word per cycle under no backpressure.
   assign slot_free = !hold_valid_q || !gb_full;
   assign accept    = (state_q == StBurst) && valid_pad[grant_q] && slot_free;
   assign burst_end = last_pad[grant_q] || (({1'b0, beat_q} + 9'd1) == 9'(MAX_BURST));

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      beat_d       = beat_q;
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      ready_pad    = '0;

      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               grant_d = pick;
               beat_d  = '0;
               state_d = StBurst;
            end
         end
         StBurst: begin
            ready_pad[grant_q] = slot_free;
            if (accept) begin
               beat_d = beat_q + 8'd1;
               if (burst_end) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (accept) begin
         hold_valid_d = 1'b1;
         hold_data_d  = data_pad[{grant_q, 4'b0000} +: 16];
      end else if (hold_valid_q && !gb_full) begin
         hold_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_400MHz or negedge res_n) begin
      if (!res_n) begin
         state_q      <= StIdle;
         grant_q      <= 3'(N_REQ - 1);
         beat_q       <= '0;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         beat_q       <= beat_d;
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
      end
   end

   assign req_ready   = ready_pad[N_REQ-1:0];
   assign gb_shift_in = hold_valid_q;
   assign gb_data_in  = hold_data_q;
   assign busy        = (state_q == StBurst) || hold_valid_q;
   assign grant_id    = grant_q;

endmodule

// File: tb/tb_gearbox_input_arbiter.sv
// Directed bench for gearbox_input_arbiter: reset, single burst, rotation, burst cap,
// backpressure and asynchronous reset mid-burst.
module tb_gearbox_input_arbiter;

   logic        clk_400MHz;
   logic        res_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_last;
   logic [63:0] req_data;
   logic [3:0]  req_ready;
   logic        gb_full;
   logic        gb_shift_in;
   logic [15:0] gb_data_in;
   logic        busy;
   logic [2:0]  grant_id;

   int checks;
   int failures;
   int w;

   gearbox_input_arbiter #(
      .N_REQ     (4),
      .MAX_BURST (8)
   ) dut (
      .clk_400MHz  (clk_400MHz),
      .res_n       (res_n),
      .req_valid   (req_valid),
      .req_last    (req_last),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .gb_full     (gb_full),
      .gb_shift_in (gb_shift_in),
      .gb_data_in  (gb_data_in),
      .busy        (busy),
      .grant_id    (grant_id)
   );

   initial clk_400MHz = 1'b0;
   always #5 clk_400MHz = ~clk_400MHz;

   task automatic step();
      @(posedge clk_400MHz);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      res_n     = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      gb_full   = 1'b0;
      step();
      step();
      res_n = 1'b1;
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      // Reset with every requester asking
      res_n     = 1'b0;
      req_valid = 4'hF;
      req_last  = 4'h0;
      req_data  = '0;
      gb_full   = 1'b0;
      step();
      step();
      chk("rst_shift", 32'(gb_shift_in), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_grant", 32'(grant_id), 3);
      chk("rst_busy", 32'(busy), 0);
      res_n = 1'b1;
      step();
      chk("rst_rel_grant", 32'(grant_id), 0);
      chk("rst_rel_ready", 32'(req_ready), 32'h1);

      // Single burst A,B,C from requester 0
      do_reset();
      req_valid = 4'b0001;
      req_data[15:0] = 16'hAAAA;
      step();
      chk("single_ready", 32'(req_ready), 32'h1);
      step();
      chk("single_shift_a", 32'(gb_shift_in), 1);
      chk("single_data_a", 32'(gb_data_in), 32'hAAAA);
      req_data[15:0] = 16'hBBBB;
      step();
      chk("single_data_b", 32'(gb_data_in), 32'hBBBB);
      req_data[15:0] = 16'hCCCC;
      req_last[0]    = 1'b1;
      step();
      chk("single_data_c", 32'(gb_data_in), 32'hCCCC);
      req_valid = '0;
      req_last  = '0;
      #1;
      chk("single_idle_ready", 32'(req_ready), 0);
      chk("single_busy_drain", 32'(busy), 1);
      step();
      chk("single_shift_end", 32'(gb_shift_in), 0);
      chk("single_busy_end", 32'(busy), 0);

      // Round-robin with 1-word bursts
      do_reset();
      req_valid = 4'hF;
      req_last  = 4'hF;
      req_data  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rr_grant", 32'(grant_id), 32'(k % 4));
         chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
         chk("rr_bubble", 32'(gb_shift_in), 0);
         step();
         chk("rr_shift", 32'(gb_shift_in), 1);
         chk("rr_data", 32'(gb_data_in), 32'hA000 + 32'(k % 4));
         chk("rr_idle_ready", 32'(req_ready), 0);
      end

      // Burst cap: 20 words from requester 2 split 8,8,4
      do_reset();
      req_valid = 4'b0100;
      w = 0;
      req_data[47:32] = 16'hC000;
      for (int b = 0; b < 3; b++) begin
         step();
         chk("cap_grant", 32'(grant_id), 2);
         chk("cap_bubble", 32'(gb_shift_in), 0);
         chk("cap_ready", 32'(req_ready), 32'h4);
         for (int j = 0; j < ((b < 2) ? 8 : 4); j++) begin
            step();
            chk("cap_shift", 32'(gb_shift_in), 1);
            chk("cap_data", 32'(gb_data_in), 32'hC000 + 32'(w));
            w++;
            req_data[47:32] = 16'(16'hC000 + w);
         end
         #1;
         chk("cap_end_ready", 32'(req_ready), (b < 2) ? 32'h0 : 32'h4);
      end
      req_valid = '0;
      step();
      chk("cap_drain_shift", 32'(gb_shift_in), 0);
      chk("cap_hold_busy", 32'(busy), 1);

      // Backpressure mid-burst from requester 1
      do_reset();
      req_valid = 4'b0010;
      req_data[31:16] = 16'hD000;
      step();
      chk("bp_grant", 32'(grant_id), 1);
      step();
      chk("bp_data0", 32'(gb_data_in), 32'hD000);
      req_data[31:16] = 16'hD001;
      gb_full = 1'b1;
      #1;
      chk("bp_ready_full", 32'(req_ready), 0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("bp_hold_shift", 32'(gb_shift_in), 1);
         chk("bp_hold_data", 32'(gb_data_in), 32'hD000);
         chk("bp_hold_ready", 32'(req_ready), 0);
      end
      gb_full = 1'b0;
      #1;
      chk("bp_resume_ready", 32'(req_ready), 32'h2);
      step();
      chk("bp_data1", 32'(gb_data_in), 32'hD001);
      chk("bp_shift1", 32'(gb_shift_in), 1);
      req_data[31:16] = 16'hD002;
      req_last[1]     = 1'b1;
      step();
      chk("bp_data2", 32'(gb_data_in), 32'hD002);
      req_valid = '0;
      req_last  = '0;
      #1;
      chk("bp_idle_ready", 32'(req_ready), 0);
      step();
      chk("bp_drain_shift", 32'(gb_shift_in), 0);

      // Asynchronous reset while a word is held
      do_reset();
      req_valid = 4'b0001;
      req_data[15:0] = 16'hE000;
      step();
      step();
      chk("mid_pre_shift", 32'(gb_shift_in), 1);
      req_valid = 4'hF;
      res_n     = 1'b0;
      #1;
      chk("mid_shift", 32'(gb_shift_in), 0);
      chk("mid_data", 32'(gb_data_in), 0);
      chk("mid_ready", 32'(req_ready), 0);
      chk("mid_busy", 32'(busy), 0);
      chk("mid_grant", 32'(grant_id), 3);
      step();
      res_n = 1'b1;
      step();
      chk("mid_restart_grant", 32'(grant_id), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
